// File: rtl/micro_op_sequencer_pkg.sv
// Shared micro-op types for the decode-to-rename sequencer.
// Default group geometry: 2 lanes x 3 micro-ops = 6 input slots.
package micro_op_sequencer_pkg;
  localparam int DECODE_WIDTH_DEF = 2;
  localparam int MICRO_OP_MAX_NUM_DEF = 3;
  localparam int ALL_DECODED_MICRO_OP_WIDTH = DECODE_WIDTH_DEF * MICRO_OP_MAX_NUM_DEF;
  localparam int ALL_DECODED_MICRO_OP_WIDTH_BIT_SIZE = $clog2(ALL_DECODED_MICRO_OP_WIDTH);

  typedef struct packed {
    logic [7:0] opcode;
    logic       mid;
    logic       last;
    logic       split;
    logic       serialized;
  } OpInfo;

  typedef logic [ALL_DECODED_MICRO_OP_WIDTH-1:0] AllDecodedMicroOpPath;

  typedef enum logic {IDLE, DRAIN} MicroOpSeqState;

  typedef logic [ALL_DECODED_MICRO_OP_WIDTH_BIT_SIZE:0] MicroOpSeqPtr;
endpackage

// File: rtl/micro_op_sequencer_compactor.sv
// Picks the (base+i)-th valid slot for each output lane.
// Slot ranks are a running popcount, so each lane matches at most one slot.
module micro_op_compactor
  import micro_op_sequencer_pkg::*;
#(
  parameter int LANES = 2,
  parameter int SLOTS = 6,
  parameter int PW    = 4
) (
  input  logic [SLOTS-1:0]  valid,
  input  OpInfo [SLOTS-1:0] mop,
  input  logic [PW-1:0]     base,
  output OpInfo [LANES-1:0] lane_mop
);
  logic [PW-1:0] rank;

  always_comb begin
    lane_mop = '0;
    rank     = '0;
    for (int s = 0; s < SLOTS; s++) begin
      for (int i = 0; i < LANES; i++)
        if (valid[s] && (rank == base + PW'(i)))
          lane_mop[i] = lane_mop[i] | mop[s];
      rank = rank + PW'(valid[s]);
    end
  end
endmodule

// File: rtl/micro_op_sequencer.sv
// Drains one decoded micro-op group in program order, DECODE_WIDTH per cycle.
// RSD_MICRO_OP_BYPASS_EN enables same-cycle pass-through of groups arriving in IDLE.
module micro_op_sequencer
  import micro_op_sequencer_pkg::*;
#(
  parameter int DECODE_WIDTH     = 2,
  parameter int MICRO_OP_MAX_NUM = 3,
  parameter int ALL_WIDTH        = MICRO_OP_MAX_NUM * DECODE_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [ALL_WIDTH-1:0]     inMopValid,
  input  OpInfo [ALL_WIDTH-1:0]    inMop,
  input  logic                     outReady,
  output logic [DECODE_WIDTH-1:0]  outValid,
  output OpInfo [DECODE_WIDTH-1:0] outMop,
  output logic                     outGroupEnd
);
  localparam int PW = $clog2(ALL_WIDTH) + 1;
  localparam logic [PW-1:0] DW = PW'(DECODE_WIDTH);

  MicroOpSeqState state, state_nx;
  logic [PW-1:0] ptr, ptr_nx, total, total_nx, in_total, base, tot, lanes, remain;
  logic [ALL_WIDTH-1:0] buf_valid, buf_valid_nx, src_valid;
  OpInfo [ALL_WIDTH-1:0] buf_mop, src_mop;
  logic accept, bypass, buf_load, active;

  always_comb begin
    in_total = '0;
    for (int s = 0; s < ALL_WIDTH; s++) in_total = in_total + PW'(inMopValid[s]);
  end

`ifdef RSD_MICRO_OP_BYPASS_EN
  assign bypass = (state == IDLE) && inValid && outReady && !flush && (in_total != '0);
`else
  assign bypass = 1'b0;
`endif

  // Bypass reads the incoming group directly; otherwise lanes come from the buffer.
  assign src_valid = bypass ? inMopValid : buf_valid;
  assign src_mop   = bypass ? inMop : buf_mop;
  assign base      = bypass ? '0 : ptr;
  assign tot       = bypass ? in_total : total;
  assign active    = !flush && ((state == DRAIN) || bypass);
  assign remain    = tot - base;
  assign lanes     = active ? ((remain > DW) ? DW : remain) : '0;

  micro_op_compactor #(.LANES(DECODE_WIDTH), .SLOTS(ALL_WIDTH), .PW(PW)) u_compactor (
    .valid(src_valid), .mop(src_mop), .base(base), .lane_mop(outMop)
  );

  always_comb begin
    for (int i = 0; i < DECODE_WIDTH; i++) outValid[i] = active && (base + PW'(i) < tot);
  end

  assign outGroupEnd = active && (base + DW >= tot);
  assign inReady     = !flush && ((state == IDLE) || ((state == DRAIN) && outReady && outGroupEnd));
  assign accept      = inValid && inReady;

  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    total_nx     = total;
    buf_valid_nx = buf_valid;
    buf_load     = 1'b0;
    if (flush) begin
      state_nx     = IDLE;
      ptr_nx       = '0;
      buf_valid_nx = '0;
    end else begin
      if ((state == DRAIN) && outReady) begin
        ptr_nx = ptr + lanes;
        if (outGroupEnd) state_nx = IDLE;
      end
      if (accept) begin
        buf_load     = 1'b1;
        buf_valid_nx = inMopValid;
        total_nx     = in_total;
        ptr_nx       = '0;
        state_nx     = (in_total == '0) ? IDLE : DRAIN;
        if (bypass) begin
          if (in_total <= DW) begin
            state_nx     = IDLE;
            buf_load     = 1'b0;
            buf_valid_nx = buf_valid;
            total_nx     = total;
          end else begin
            ptr_nx = DW;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      total     <= '0;
      buf_valid <= '0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      total     <= total_nx;
      buf_valid <= buf_valid_nx;
    end
  end

  // Payload is qualified by buf_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (buf_load) buf_mop <= inMop;
  end
endmodule

// File: tb/tb_micro_op_sequencer.sv
// Scoreboard bench for micro_op_sequencer: expected beats queued by stimulus, popped by monitor.
module tb_micro_op_sequencer;
  import micro_op_sequencer_pkg::*;

  logic clk = 1'b0, rst, flush, in_valid, in_ready, out_ready, out_group_end;
  logic [5:0] in_mop_valid;
  OpInfo [5:0] in_mop;
  logic [1:0] out_valid;
  OpInfo [1:0] out_mop;

  typedef struct {
    logic [1:0]  v;
    logic [11:0] m0;
    logic [11:0] m1;
    logic        ge;
  } beat_t;

  beat_t q[$];
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  micro_op_sequencer dut (
    .clk(clk), .rst(rst), .flush(flush), .inValid(in_valid), .inReady(in_ready),
    .inMopValid(in_mop_valid), .inMop(in_mop), .outReady(out_ready),
    .outValid(out_valid), .outMop(out_mop), .outGroupEnd(out_group_end)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic OpInfo mk(input int g, input int s);
    OpInfo o;
    o.opcode     = 8'(g * 16 + s);
    o.mid        = s[0];
    o.last       = s[1];
    o.split      = s[2];
    o.serialized = g[0];
    return o;
  endfunction

  task automatic push(input logic [1:0] v, input int g, input int s0, input int s1, input logic ge);
    beat_t b;
    b.v  = v;
    b.m0 = mk(g, s0);
    b.m1 = mk(g, s1);
    b.ge = ge;
    q.push_back(b);
  endtask

  task automatic drive(input logic [5:0] v, input int g);
    in_valid     = 1'b1;
    in_mop_valid = v;
    for (int s = 0; s < 6; s++) in_mop[s] = mk(g, s);
  endtask

  // Presents a group and returns just after the edge that accepted it.
  task automatic present(input logic [5:0] v, input int g);
    int budget;
    drive(v, g);
    budget = 0;
    @(negedge clk);
    while (!in_ready && budget < 20) begin
      budget++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_out_valid"}, int'(out_valid), 0);
    check({nm, "_in_ready"}, int'(in_ready), 1);
  endtask

  always @(negedge clk) begin
    beat_t b;
    if (!rst && out_ready && out_valid != 2'b00) begin
      if (q.size() == 0) begin
        check("unexpected_beat", int'(out_valid), 0);
      end else begin
        b = q.pop_front();
        check("lane_valid", int'(out_valid), int'(b.v));
        check("lane0_mop", int'(out_mop[0]), int'(b.m0));
        if (b.v[1]) check("lane1_mop", int'(out_mop[1]), int'(b.m1));
        check("group_end", int'(out_group_end), int'(b.ge));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mop_valid = '0; in_mop = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_group_end", int'(out_group_end), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // full six-op group, three drain cycles
    push(2'b11, 1, 0, 1, 0); push(2'b11, 1, 2, 3, 0); push(2'b11, 1, 4, 5, 1);
    present(6'b111111, 1); in_valid = 1'b0;
    @(negedge clk);
`ifndef RSD_MICRO_OP_BYPASS_EN
    check("t1_c1_in_ready", int'(in_ready), 0);
`endif
    @(negedge clk); @(negedge clk);
`ifndef RSD_MICRO_OP_BYPASS_EN
    check("t1_c3_in_ready", int'(in_ready), 1);
    check("t1_c3_group_end", int'(out_group_end), 1);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    check_idle("t1_end");
    @(posedge clk); #1;

    // sparse group compacts to {0,2},{5}
    push(2'b11, 2, 0, 2, 0); push(2'b01, 2, 5, 0, 1);
    present(6'b100101, 2); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("t2_end");
    @(posedge clk); #1;

    // rename stalled for two cycles after accept
    out_ready = 1'b0;
    push(2'b11, 3, 0, 1, 0); push(2'b11, 3, 2, 3, 1);
    present(6'b001111, 3); in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("t3_hold_valid", int'(out_valid), 3);
      check("t3_hold_lane0", int'(out_mop[0]), int'(mk(3, 0)));
      check("t3_hold_lane1", int'(out_mop[1]), int'(mk(3, 1)));
      check("t3_hold_in_ready", int'(in_ready), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("t3_end");
    @(posedge clk); #1;

    // back-to-back groups, B loads in A's last drain cycle
    push(2'b11, 4, 0, 1, 0); push(2'b11, 4, 2, 3, 1); push(2'b11, 5, 0, 1, 1);
    present(6'b001111, 4);
    present(6'b000011, 5); in_valid = 1'b0;
    @(negedge clk);
    check("t4_no_bubble", int'(out_valid), 3);
    @(negedge clk);
    check_idle("t4_end");
    @(posedge clk); #1;

    // flush mid-drain drops held and incoming groups
    push(2'b11, 6, 0, 1, 0);
`ifdef RSD_MICRO_OP_BYPASS_EN
    push(2'b11, 6, 2, 3, 0);
`endif
    present(6'b111111, 6); in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    drive(6'b111111, 7);
    @(negedge clk);
    check("t5_flush_out_valid", int'(out_valid), 0);
    check("t5_flush_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_idle("t5_after");
    @(posedge clk); #1;

    // small group: same-cycle with bypass, next cycle without
    push(2'b11, 8, 0, 1, 1);
    drive(6'b000011, 8);
    @(negedge clk);
`ifdef RSD_MICRO_OP_BYPASS_EN
    check("t6_same_cycle", int'(out_valid), 3);
`else
    check("t6_same_cycle", int'(out_valid), 0);
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
`ifdef RSD_MICRO_OP_BYPASS_EN
    check("t6_next_cycle", int'(out_valid), 0);
`else
    check("t6_next_cycle", int'(out_valid), 3);
`endif
    @(negedge clk);
    check_idle("t6_end");

    repeat (2) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
